// File: rtl/warp_dispatcher.sv
// Binds accepted kernels to the lowest idle SIMD core and returns finished warp IDs one per cycle.
// Optional per-core watchdog is built when WARP_DISPATCH_TIMEOUT_EN is defined.
module warp_dispatcher #(
    parameter int unsigned NUM_SIMD_CORES    = 4,
    parameter int unsigned LOG2_THREAD_COUNT = 3
`ifdef WARP_DISPATCH_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES  = 1024
`endif
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           valid_kernel,
    input  logic [3:0]                                     kernel_warp_id,
    input  logic [31:0]                                    kernel_pc,
    input  logic [LOG2_THREAD_COUNT-1:0]                   kernel_num_threads,
    output logic                                           kernel_ready,
    output logic [NUM_SIMD_CORES-1:0]                      core_start,
    output logic [32*NUM_SIMD_CORES-1:0]                   core_pc,
    output logic [(2**LOG2_THREAD_COUNT)*NUM_SIMD_CORES-1:0] core_thread_mask,
    input  logic [NUM_SIMD_CORES-1:0]                      core_done,
    output logic [3:0]                                     finished_warp_id,
    output logic [NUM_SIMD_CORES-1:0]                      timeout
);

    localparam int unsigned THREAD_COUNT = 2**LOG2_THREAD_COUNT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_PENDING
    } core_state_e;

    core_state_e               state_q   [NUM_SIMD_CORES];
    core_state_e               state_d   [NUM_SIMD_CORES];
    logic [3:0]                warp_id_q [NUM_SIMD_CORES];
    logic [3:0]                warp_id_d [NUM_SIMD_CORES];
    logic [31:0]               pc_q      [NUM_SIMD_CORES];
    logic [31:0]               pc_d      [NUM_SIMD_CORES];
    logic [THREAD_COUNT-1:0]   mask_q    [NUM_SIMD_CORES];
    logic [THREAD_COUNT-1:0]   mask_d    [NUM_SIMD_CORES];
    logic [NUM_SIMD_CORES-1:0] start_q, start_d;
    logic [3:0]                fin_q, fin_d;
    logic [THREAD_COUNT-1:0]   new_mask;
    logic                      zero_thr;
    logic                      alloc_found;
    logic                      rep_found;

`ifdef WARP_DISPATCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]          cnt_q [NUM_SIMD_CORES];
    logic [CNT_W-1:0]          cnt_d [NUM_SIMD_CORES];
    logic [NUM_SIMD_CORES-1:0] timeout_q, timeout_d;
`endif

    always_comb begin
        new_mask = '0;
        for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
            new_mask[t] = (t < 32'(kernel_num_threads));
        end
        zero_thr = (kernel_num_threads == '0);
    end

    // Reporting and allocation both look at registered state only, so a core
    // freed this edge is allocatable next edge and a new PENDING waits a cycle.
    always_comb begin
        start_d     = '0;
        fin_d       = 4'hF;
        alloc_found = 1'b0;
        rep_found   = 1'b0;
`ifdef WARP_DISPATCH_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
            state_d[i]   = state_q[i];
            warp_id_d[i] = warp_id_q[i];
            pc_d[i]      = pc_q[i];
            mask_d[i]    = mask_q[i];
`ifdef WARP_DISPATCH_TIMEOUT_EN
            cnt_d[i]     = cnt_q[i];
`endif
            unique case (state_q[i])
                S_PENDING: begin
                    if (!rep_found) begin
                        rep_found  = 1'b1;
                        fin_d      = warp_id_q[i];
                        state_d[i] = S_IDLE;
                    end
                end
                S_BUSY: begin
`ifdef WARP_DISPATCH_TIMEOUT_EN
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    if (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d[i]   = S_PENDING;
                        timeout_d[i] = 1'b1;
                    end
`endif
                    if (core_done[i]) begin
                        state_d[i] = S_PENDING;
                    end
                end
                S_IDLE: begin
                    if (valid_kernel && !alloc_found) begin
                        alloc_found  = 1'b1;
                        warp_id_d[i] = kernel_warp_id;
                        pc_d[i]      = kernel_pc;
                        mask_d[i]    = new_mask;
                        state_d[i]   = zero_thr ? S_PENDING : S_BUSY;
                        start_d[i]   = !zero_thr;
`ifdef WARP_DISPATCH_TIMEOUT_EN
                        cnt_d[i]     = '0;
`endif
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            fin_q   <= 4'hF;
            for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
                state_q[i]   <= S_IDLE;
                warp_id_q[i] <= '0;
                pc_q[i]      <= '0;
                mask_q[i]    <= '0;
            end
        end else begin
            start_q <= start_d;
            fin_q   <= fin_d;
            for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
                state_q[i]   <= state_d[i];
                warp_id_q[i] <= warp_id_d[i];
                pc_q[i]      <= pc_d[i];
                mask_q[i]    <= mask_d[i];
            end
        end
    end

`ifdef WARP_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= '0;
            for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            timeout_q <= timeout_d;
            for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = '0;
`endif

    always_comb begin
        kernel_ready     = 1'b0;
        core_pc          = '0;
        core_thread_mask = '0;
        for (int unsigned i = 0; i < NUM_SIMD_CORES; i++) begin
            kernel_ready = kernel_ready | (state_q[i] == S_IDLE);
            core_pc[i*32 +: 32] = pc_q[i];
            core_thread_mask[i*THREAD_COUNT +: THREAD_COUNT] = mask_q[i];
        end
    end

    assign core_start       = start_q;
    assign finished_warp_id = fin_q;

endmodule

// File: tb/tb_warp_dispatcher.sv
// Directed table-driven bench for warp_dispatcher plus hand-written watchdog sequence.
module tb_warp_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_kernel;
    logic [3:0]  kernel_warp_id;
    logic [31:0] kernel_pc;
    logic [2:0]  kernel_num_threads;
    logic        kernel_ready;
    logic [3:0]  core_start;
    logic [127:0] core_pc;
    logic [31:0] core_thread_mask;
    logic [3:0]  core_done;
    logic [3:0]  finished_warp_id;
    logic [3:0]  timeout;

    int errors = 0;
    int checks = 0;

`ifdef WARP_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    warp_dispatcher #(
        .NUM_SIMD_CORES(4),
        .LOG2_THREAD_COUNT(3)
`ifdef WARP_DISPATCH_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_kernel       (valid_kernel),
        .kernel_warp_id     (kernel_warp_id),
        .kernel_pc          (kernel_pc),
        .kernel_num_threads (kernel_num_threads),
        .kernel_ready       (kernel_ready),
        .core_start         (core_start),
        .core_pc            (core_pc),
        .core_thread_mask   (core_thread_mask),
        .core_done          (core_done),
        .finished_warp_id   (finished_warp_id),
        .timeout            (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [3:0]  id;
        logic [31:0] pc;
        logic [2:0]  n;
        logic [3:0]  done;
        logic        exp_ready;
        logic [3:0]  exp_start;
        logic [3:0]  exp_fin;
        logic        chk_pm;
        int          pm_core;
        logic [31:0] exp_pc;
        logic [7:0]  exp_mask;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [3:0] id, input logic [31:0] pc,
                       input logic [2:0] n, input logic [3:0] done, input logic er,
                       input logic [3:0] es, input logic [3:0] ef, input logic cpm,
                       input int c, input logic [31:0] epc, input logic [7:0] em);
        vec_t x;
        x.rst = r; x.valid = v; x.id = id; x.pc = pc; x.n = n; x.done = done;
        x.exp_ready = er; x.exp_start = es; x.exp_fin = ef;
        x.chk_pm = cpm; x.pm_core = c; x.exp_pc = epc; x.exp_mask = em;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] id, input logic [31:0] pc,
                         input logic [2:0] n, input logic [3:0] done);
        rst = r; valid_kernel = v; kernel_warp_id = id; kernel_pc = pc;
        kernel_num_threads = n; core_done = done;
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'h0, 32'h0, 3'd0, 4'b0000);

        //   rst v  id     pc            n     done     rdy start    fin    pm c  pc            mask
        add(1, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 1, 4'h2, 32'h8765_4321,3'd2, 4'b0000, 1, 4'b0001, 4'hF, 1, 0, 32'h8765_4321,8'h03);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 1, 0, 32'h8765_4321,8'h03);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0001, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'h2, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        // fill all four cores, fifth kernel held
        add(0, 1, 4'h0, 32'h0000_1000,3'd4, 4'b0000, 1, 4'b0001, 4'hF, 1, 0, 32'h0000_1000,8'h0F);
        add(0, 1, 4'h1, 32'h0000_2000,3'd2, 4'b0000, 1, 4'b0010, 4'hF, 1, 1, 32'h0000_2000,8'h03);
        add(0, 1, 4'h2, 32'h0000_3000,3'd7, 4'b0000, 1, 4'b0100, 4'hF, 1, 2, 32'h0000_3000,8'h7F);
        add(0, 1, 4'h3, 32'h0000_4000,3'd1, 4'b0000, 0, 4'b1000, 4'hF, 1, 3, 32'h0000_4000,8'h01);
        add(0, 1, 4'h4, 32'h0000_5000,3'd3, 4'b0000, 0, 4'b0000, 4'hF, 1, 0, 32'h0000_1000,8'h0F);
        add(0, 1, 4'h4, 32'h0000_5000,3'd3, 4'b0010, 0, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 1, 4'h4, 32'h0000_5000,3'd3, 4'b0000, 1, 4'b0000, 4'h1, 0, 0, 32'h0,        8'h00);
        add(0, 1, 4'h4, 32'h0000_5000,3'd3, 4'b0000, 0, 4'b0010, 4'hF, 1, 1, 32'h0000_5000,8'h07);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 0, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        // simultaneous done on cores 0,1,3 (ids 0,4,3)
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b1011, 0, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'h0, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'h4, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'h3, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0001, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0100, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'h2, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0100, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        // zero-thread kernel
        add(0, 1, 4'h5, 32'h0000_6000,3'd0, 4'b0000, 1, 4'b0000, 4'hF, 1, 0, 32'h0000_6000,8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'h5, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        // reset with two busy and one pending core
        add(0, 1, 4'h6, 32'h0000_7000,3'd1, 4'b0000, 1, 4'b0001, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 1, 4'h7, 32'h0000_7100,3'd1, 4'b0000, 1, 4'b0010, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 1, 4'h8, 32'h0000_7200,3'd1, 4'b0000, 1, 4'b0100, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0001, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(1, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 1, 1, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0111, 1, 4'b0000, 4'hF, 1, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);
        add(0, 0, 4'h0, 32'h0,        3'd0, 4'b0000, 1, 4'b0000, 4'hF, 0, 0, 32'h0,        8'h00);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].valid, vecs[k].id, vecs[k].pc, vecs[k].n, vecs[k].done);
            step();
            check($sformatf("v%0d ready", k), 32'(kernel_ready), 32'(vecs[k].exp_ready));
            check($sformatf("v%0d start", k), 32'(core_start), 32'(vecs[k].exp_start));
            check($sformatf("v%0d fin", k), 32'(finished_warp_id), 32'(vecs[k].exp_fin));
            check($sformatf("v%0d timeout", k), 32'(timeout), 32'h0);
            if (vecs[k].chk_pm) begin
                check($sformatf("v%0d pc[%0d]", k, vecs[k].pm_core),
                      core_pc[vecs[k].pm_core*32 +: 32], vecs[k].exp_pc);
                check($sformatf("v%0d mask[%0d]", k, vecs[k].pm_core),
                      32'(core_thread_mask[vecs[k].pm_core*8 +: 8]), 32'(vecs[k].exp_mask));
            end
        end

        // Watchdog: no core_done for a busy core; with the watchdog built the ID
        // comes back 17 cycles after accept, otherwise the core stays busy.
        drive(0, 1, 4'h9, 32'h0000_8000, 3'd3, 4'b0000);
        step();
        check("wd accept start", 32'(core_start), 32'h1);
        drive(0, 0, 4'h0, 32'h0, 3'd0, 4'b0000);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("wd fin +%0d", k), 32'(finished_warp_id),
                  (TO_EN && k == 17) ? 32'h9 : 32'hF);
            check($sformatf("wd timeout +%0d", k), 32'(timeout),
                  (TO_EN && k >= 16) ? 32'h1 : 32'h0);
        end
        drive(0, 0, 4'h0, 32'h0, 3'd0, 4'b0001);
        step();
        check("wd late done fin", 32'(finished_warp_id), 32'hF);
        drive(0, 0, 4'h0, 32'h0, 3'd0, 4'b0000);
        step();
        check("wd after done fin", 32'(finished_warp_id), TO_EN ? 32'hF : 32'h9);
        check("wd sticky timeout", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
        drive(1, 0, 4'h0, 32'h0, 3'd0, 4'b0000);
        step();
        check("wd rst timeout", 32'(timeout), 32'h0);
        check("wd rst fin", 32'(finished_warp_id), 32'hF);
        check("wd rst ready", 32'(kernel_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
